// File: rtl/mem_io_pkg.sv
// Shared constants for the memory/IO bridge: region codes, peripheral
// addresses and the timer state type, also used by processor test programs.
package mem_io_pkg;

    localparam logic [2:0] REG_RAM  = 3'd0;
    localparam logic [2:0] REG_LED  = 3'd1;
    localparam logic [2:0] REG_HEX  = 3'd2;
    localparam logic [2:0] REG_SW   = 3'd3;
    localparam logic [2:0] REG_TMR  = 3'd4;
    localparam logic [2:0] REG_NONE = 3'd7;

    localparam logic [15:0] ADDR_LEDR   = 16'h1000;
    localparam logic [15:0] ADDR_HEX    = 16'h2000;
    localparam logic [15:0] ADDR_SW     = 16'h3000;
    localparam logic [15:0] ADDR_TCOUNT = 16'h4000;
    localparam logic [15:0] ADDR_TSTAT  = 16'h4001;

    typedef enum logic [1:0] {
        TMR_IDLE    = 2'd0,
        TMR_RUN     = 2'd1,
        TMR_EXPIRED = 2'd2
    } tmr_state_t;

    // RAM owns the whole 0x0xxx page; peripherals decode their exact address.
    function automatic logic [2:0] decode_region(input logic [15:0] addr);
        logic [2:0] region_s;
        if (addr[15:12] == 4'h0) begin
            region_s = REG_RAM;
        end else if (addr == ADDR_LEDR) begin
            region_s = REG_LED;
        end else if (addr == ADDR_HEX) begin
            region_s = REG_HEX;
        end else if (addr == ADDR_SW) begin
            region_s = REG_SW;
        end else if ((addr == ADDR_TCOUNT) || (addr == ADDR_TSTAT)) begin
            region_s = REG_TMR;
        end else begin
            region_s = REG_NONE;
        end
        return region_s;
    endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// Processor-side bus of the bridge: registered address, write data, write
// enable, and the read data returned two cycles later.
interface mem_io_bridge_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;

    modport master (output ADDR, output DOUT, output W, input DIN);
    modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/io_timer.sv
// Countdown timer: a CLK_DIV prescaler drives a 16-bit count down to zero,
// then a sticky expired flag holds until the next load.
module io_timer
    import mem_io_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        expired
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    tmr_state_t    state_r;
    logic [PW-1:0] presc_r;
    logic [15:0]   count_r;
    logic          expired_r;

    // Timer FSM; a load always wins over a coincident prescaler wrap.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r   <= TMR_IDLE;
            presc_r   <= '0;
            count_r   <= 16'd0;
            expired_r <= 1'b0;
        end else if (load) begin
            count_r   <= load_val;
            presc_r   <= '0;
            expired_r <= 1'b0;
            state_r   <= (load_val != 16'd0) ? TMR_RUN : TMR_IDLE;
        end else begin
            case (state_r)
                TMR_RUN: begin
                    if (presc_r == PRESC_MAX) begin
                        presc_r <= '0;
                        if (count_r <= 16'd1) begin
                            count_r   <= 16'd0;
                            expired_r <= 1'b1;
                            state_r   <= TMR_EXPIRED;
                        end else begin
                            count_r <= count_r - 16'd1;
                        end
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end
                TMR_IDLE, TMR_EXPIRED: begin
                    presc_r <= '0;
                    count_r <= 16'd0;
                end
                default: begin
                    state_r   <= TMR_IDLE;
                    presc_r   <= '0;
                    count_r   <= 16'd0;
                    expired_r <= 1'b0;
                end
            endcase
        end
    end

    assign count   = count_r;
    assign expired = expired_r;

endmodule

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge: decodes the processor bus onto a synchronous RAM and the
// LED/HEX/SW/timer peripherals, returning read data with two-cycle latency.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int RAM_AW  = 7,
    parameter int CLK_DIV = 50000
) (
    input  logic              Clock,
    input  logic              Resetn,
    mem_io_bridge_if.slave    bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    input  logic [15:0]       ram_rdata,
    input  logic [9:0]        SW,
    output logic [9:0]        LEDR,
    output logic [15:0]       hex_val,
    output logic              timer_expired
);

    logic [2:0]  region_s;
    logic [15:0] periph_rdata_s;
    logic        tmr_load_s;
    logic [15:0] tmr_count_s;
    logic        tmr_expired_s;
    logic [9:0]  led_r;
    logic [15:0] hex_r;
    logic        ram_sel_r;
    logic [15:0] periph_r;
    logic [15:0] din_r;

    assign region_s   = decode_region(bus.ADDR);
    assign ram_addr   = bus.ADDR[RAM_AW-1:0];
    assign ram_wdata  = bus.DOUT;
    assign ram_we     = bus.W && (region_s == REG_RAM);
    assign tmr_load_s = bus.W && (bus.ADDR == ADDR_TCOUNT);

    io_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load     (tmr_load_s),
        .load_val (bus.DOUT),
        .count    (tmr_count_s),
        .expired  (tmr_expired_s)
    );

    // Peripheral read mux, sampled by stage 1 of the read pipeline.
    always_comb begin
        periph_rdata_s = 16'h0000;
        case (region_s)
            REG_LED: periph_rdata_s = {6'd0, led_r};
            REG_HEX: periph_rdata_s = hex_r;
            REG_SW:  periph_rdata_s = {6'd0, SW};
            REG_TMR: begin
                if (bus.ADDR[0]) begin
                    periph_rdata_s = {15'd0, tmr_expired_s};
                end else begin
                    periph_rdata_s = tmr_count_s;
                end
            end
            default: periph_rdata_s = 16'h0000;
        endcase
    end

    // LED and HEX registers; repeated writes simply overwrite.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            led_r <= 10'd0;
            hex_r <= 16'h0000;
        end else begin
            if (bus.W && (region_s == REG_LED)) begin
                led_r <= bus.DOUT[9:0];
            end
            if (bus.W && (region_s == REG_HEX)) begin
                hex_r <= bus.DOUT;
            end
        end
    end

    // Two-stage read pipeline aligned with the RAM's one-cycle read.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ram_sel_r <= 1'b0;
            periph_r  <= 16'h0000;
            din_r     <= 16'h0000;
        end else begin
            ram_sel_r <= (region_s == REG_RAM);
            periph_r  <= periph_rdata_s;
            din_r     <= ram_sel_r ? ram_rdata : periph_r;
        end
    end

    assign bus.DIN       = din_r;
    assign LEDR          = led_r;
    assign hex_val       = hex_r;
    assign timer_expired = tmr_expired_s;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomized bench for mem_io_bridge against an abstract model of the
// address map and a closed-form timer model (CLK_DIV = 4).
module tb_mem_io_bridge;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata = 16'h0000;
    logic [9:0]  sw = 10'd0;
    logic [9:0]  ledr;
    logic [15:0] hex_val;
    logic        timer_expired;
    logic [15:0] ram_mem [128];

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    // abstract model state
    logic [15:0] ref_ram [128];
    logic [9:0]  ref_led = 10'd0;
    logic [15:0] ref_hex = 16'h0000;
    int          tload_val = 0;
    int          tload_edge = 0;

    mem_io_bridge_if bus ();

    mem_io_bridge #(.RAM_AW(7), .CLK_DIV(CLK_DIV)) dut (
        .Clock         (clk),
        .Resetn        (rst_n),
        .bus           (bus),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_rdata     (ram_rdata),
        .SW            (sw),
        .LEDR          (ledr),
        .hex_val       (hex_val),
        .timer_expired (timer_expired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Synchronous RAM with read-old-data behaviour.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_count(input int cap);
        int d;
        if (tload_val == 0) return 0;
        d = (cap - tload_edge) / CLK_DIV;
        return (d >= tload_val) ? 0 : tload_val - d;
    endfunction

    function automatic logic model_expired(input int at_edge);
        return (tload_val != 0) && ((at_edge - tload_edge) >= tload_val * CLK_DIV);
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a, input int cap);
        if (a[15:12] == 4'h0)      return ref_ram[a[6:0]];
        else if (a == 16'h1000)    return {6'd0, ref_led};
        else if (a == 16'h2000)    return ref_hex;
        else if (a == 16'h3000)    return {6'd0, sw};
        else if (a == 16'h4000)    return 16'(model_count(cap));
        else if (a == 16'h4001)    return {15'd0, model_expired(cap)};
        else                       return 16'h0000;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [15:0] d, input int at_edge);
        if (a[15:12] == 4'h0)      ref_ram[a[6:0]] = d;
        else if (a == 16'h1000)    ref_led = d[9:0];
        else if (a == 16'h2000)    ref_hex = d;
        else if (a == 16'h4000) begin
            tload_val  = int'(d);
            tload_edge = at_edge;
        end
    endtask

    // nstore=3: processor store with stale first cycle; nstore=1: single-edge write
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] stale, input int nstore);
        @(negedge clk);
        bus.ADDR = a;
        bus.W    = 1'b1;
        bus.DOUT = (nstore > 1) ? stale : d;
        #1 check_val("ram_we", {15'd0, ram_we}, {15'd0, (a[15:12] == 4'h0)});
        for (int i = 1; i < nstore; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus.DOUT = d;
        end
        @(posedge clk);
        #1 model_write(a, d, edge_cnt);
        @(negedge clk);
        bus.W    = 1'b0;
        bus.ADDR = 16'h7000;
        check_val("ledr", {6'd0, ledr}, {6'd0, ref_led});
        check_val("hex_val", hex_val, ref_hex);
    endtask

    task automatic bus_read(input logic [15:0] a, input string tag);
        int e1;
        logic [15:0] exp1;
        @(negedge clk);
        bus.ADDR = a;
        bus.W    = 1'b0;
        bus.DOUT = 16'($urandom);
        @(posedge clk);
        #1 e1 = edge_cnt;
        exp1 = model_read(a, e1 - 1);
        @(posedge clk);
        @(negedge clk);
        check_val(tag, bus.DIN, exp1);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_hold"}, bus.DIN, model_read(a, e1));
    endtask

    task automatic tick_check(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_val("tmr_exp", {15'd0, timer_expired}, {15'd0, model_expired(edge_cnt)});
        end
    endtask

    function automatic logic [15:0] pick_addr(input int kind);
        case (kind)
            0: return {4'h0, 12'($urandom)};
            1: return 16'h1000;
            2: return 16'h2000;
            3: return 16'h3000;
            4: return 16'h4000;
            5: return 16'h4001;
            default: return ($urandom_range(0, 1) == 0) ? {4'(5 + $urandom_range(0, 10)), 12'($urandom)}
                                                      : {4'h1, 12'($urandom_range(1, 4095))};
        endcase
    endfunction

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        int kind;
        int l0;
        bus.ADDR = 16'h7000;
        bus.DOUT = 16'h0000;
        bus.W    = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_din", bus.DIN, 16'h0000);
        check_val("rst_ledr", {6'd0, ledr}, 16'h0000);
        check_val("rst_hex", hex_val, 16'h0000);
        check_val("rst_exp", {15'd0, timer_expired}, 16'h0000);
        rst_n = 1'b1;

        // give every RAM word a known value
        for (int i = 0; i < 128; i++) bus_write(16'(i), 16'($urandom), 16'h0000, 1);

        // RAM round-trip with stale first store cycle
        bus_write(16'h0005, 16'h1234, 16'hFFFF, 3);
        bus_read(16'h0005, "ram_rt");
        bus_read(16'h0F85, "ram_alias");

        // peripherals
        bus_write(16'h1000, 16'h03FF, 16'($urandom), 3);
        check_val("ledr_3ff", {6'd0, ledr}, 16'h03FF);
        sw = 10'h2A5;
        bus_read(16'h3000, "sw_rd");
        bus_write(16'h3000, 16'hFFFF, 16'($urandom), 3);
        bus_read(16'h1000, "led_rd");

        // unmapped
        bus_read(16'h7000, "unmapped_rd");
        bus_write(16'h5000, 16'hBEEF, 16'($urandom), 3);
        bus_read(16'h2000, "hex_after_unm");

        // timer: load 3 expires 12 clocks after the last write edge
        bus_write(16'h4000, 16'd3, 16'($urandom), 3);
        tick_check(14);
        bus_read(16'h4001, "tstat_exp");
        bus_write(16'h4000, 16'd0, 16'($urandom), 3);
        tick_check(10);
        bus_read(16'h4001, "tstat_clr");

        // timer: single-edge load coincident with a prescaler wrap
        bus_write(16'h4000, 16'd5, 16'($urandom), 3);
        l0 = tload_edge;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.ADDR = 16'h4000;
        bus.DOUT = 16'd2;
        bus.W    = 1'b1;
        @(posedge clk);
        #1 model_write(16'h4000, 16'd2, edge_cnt);
        if (edge_cnt != l0 + CLK_DIV) $display("note: collision edge offset %0d", edge_cnt - l0);
        @(negedge clk);
        bus.W = 1'b0;
        bus_read(16'h4000, "tmr_collide");
        tick_check(8);

        // randomized mix of writes and reads
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 6);
            a = pick_addr(kind);
            if ($urandom_range(0, 3) == 0) sw = 10'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                d = (kind == 4) ? 16'($urandom_range(0, 6)) : 16'($urandom);
                bus_write(a, d, 16'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 3);
            end else begin
                bus_read(a, "rand_rd");
            end
            check_val("rand_exp", {15'd0, timer_expired}, {15'd0, model_expired(edge_cnt)});
        end

        // reset in the middle of a read
        bus_write(16'h1000, 16'h0155, 16'($urandom), 3);
        bus_write(16'h2000, 16'hA5A5, 16'($urandom), 3);
        bus_write(16'h4000, 16'd1, 16'($urandom), 3);
        tick_check(6);
        @(negedge clk);
        bus.ADDR = 16'h1000;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_din", bus.DIN, 16'h0000);
        check_val("mid_rst_ledr", {6'd0, ledr}, 16'h0000);
        check_val("mid_rst_hex", hex_val, 16'h0000);
        check_val("mid_rst_exp", {15'd0, timer_expired}, 16'h0000);
        ref_led = 10'd0;
        ref_hex = 16'h0000;
        tload_val = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(16'h4000, "post_rst_cnt");
        bus_read(16'h1000, "post_rst_led");
        tick_check(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Memory/IO bridge directly downstream of the processor: takes its registered `ADDR`, `DOUT` and `W` and routes them to a synchronous program/data RAM and a small set of memory-mapped peripherals. The peripherals are LEDs, a hex-display value, switches and a countdown timer. It returns read data on the processor's `DIN` with a fixed two-cycle latency, matching the processor's two wait states before it latches `IR` or a load result.

## Interface

**Parameters**
- `RAM_AW`, default 7: RAM word-address width (128 × 16-bit words).
- `CLK_DIV`, default 50000: timer prescaler; 1 timer tick per `CLK_DIV` clocks; must be ≥ 2.

**Ports**
- `Clock`, in, 1: system clock, rising edge.
- `Resetn`, in, 1: asynchronous, active-low reset.
- `ADDR`, in, 16: word address from the processor.
- `DOUT`, in, 16: write data from the processor.
- `W`, in, 1: write enable from the processor.
- `DIN`, out, 16: read data to the processor, registered.
- `ram_addr`, out, RAM_AW: equal to `ADDR[RAM_AW-1:0]`, combinational.
- `ram_wdata`, out, 16: equal to `DOUT`, combinational.
- `ram_we`, out, 1: `W` AND RAM region, combinational.
- `ram_rdata`, in, 16: synchronous RAM output, 1-cycle read latency.
- `SW`, in, 10: board switches, already synchronised.
- `LEDR`, out, 10: LED register.
- `hex_val`, out, 16: four-nibble display value; decoding is done elsewhere.
- `timer_expired`, out, 1: sticky timer-expired flag.

## Operation

**Address map.** Decode on `ADDR[15:12]`; low bits are exact where noted.
- `0x0xxx`: RAM, read/write, index `ADDR[RAM_AW-1:0]`; upper bits within the region alias.
- `0x1000`: LEDR, read/write, bits [9:0]; reads zero-extend.
- `0x2000`: HEX, read/write, 16 bits.
- `0x3000`: SW, read-only, zero-extended; writes ignored.
- `0x4000`: TCOUNT, read/write, current timer count.
- `0x4001`: TSTAT, read-only, bit0 = expired, other bits 0.
- Any other address: reads return 0, writes ignored.

**Writes**
- Take effect on every rising edge with `W`=1; the last write wins.
- The processor's store sequence holds `W` high for three consecutive cycles, and the first of these carries stale `DOUT`. Every register write must therefore be idempotent and have no side effects beyond the final value.

**Read pipeline**
- Stage 1 (edge after `ADDR` valid): register the region select and the peripheral read value.
- Stage 2: `DIN` ← `ram_rdata` if the region is RAM, else the stage-1 peripheral value.

**Timer** (sub-module). States are IDLE (count = 0, not expired), RUN and EXPIRED.
- Write to TCOUNT: count ← `DOUT`, prescaler ← 0, expired ← 0. Next state is RUN if `DOUT` ≠ 0, else IDLE; writing 0 never sets expired.
- RUN: the prescaler counts 0 to `CLK_DIV-1` and wraps. On wrap, count decrements. When count goes 1 → 0, expired ← 1 and the state becomes EXPIRED.
- EXPIRED: count stays 0 and the flag holds until the next TCOUNT write.
- A write in the same cycle as a prescaler wrap: the write wins and no decrement occurs.
- `timer_expired` equals the expired flag.

## Timing

**Reset values** (asynchronous on `Resetn`=0): `DIN`=0, `LEDR`=0, `hex_val`=0, `timer_expired`=0, count=0, prescaler=0, timer state IDLE, pipeline registers 0. `ram_*` outputs follow their inputs combinationally.

**Read latency**
- `ADDR` changes after edge E0; `DIN` reflects that address after edge E2.
- `DIN` stays stable while `ADDR` is stable.
- Latency is identical for RAM and peripheral reads.

**Write-to-read visibility**
- A register written at edge E is returned by a read whose `ADDR` is presented after E.
- RAM write/read ordering follows the RAM's read-during-write behaviour. The bridge adds no bypass.

**Timer rate**
- With a load of N ≥ 1, the expired flag rises exactly N·`CLK_DIV` clocks after the last write edge.
- TCOUNT and TSTAT reads see values as of stage-1 capture.

**Reset mid-operation:** all state returns to reset values immediately. The in-flight read is discarded and `DIN` = 0.

## Structure

- **Shared package** `mem_io_pkg`: region codes (`REG_RAM`=0, `REG_LED`=1, `REG_HEX`=2, `REG_SW`=3, `REG_TMR`=4), full addresses of LEDR/HEX/SW/TCOUNT/TSTAT, and the timer state enum. The processor's test programs use the same constants.
- **Sub-module** `io_timer` (ports: `Clock`, `Resetn`, `load`, `load_val`, `count`, `expired`) holds the prescaler, count and FSM. The bridge keeps decode, the LED/HEX registers and the read pipeline.

## Test plan

- **RAM round-trip:** write `0x1234` to `0x0005` with `W` held 3 cycles, first cycle `DOUT`=`0xFFFF` → later read of `0x0005` gives `DIN`=`0x1234` exactly 2 cycles after `ADDR`.
- **Peripherals:** write `0x03FF` to `0x1000` → `LEDR`=`0x3FF`. With `SW`=`0x2A5`, read `0x3000` → `DIN`=`0x02A5`. Write to `0x3000` leaves all state unchanged.
- **Unmapped:** read `0x7000` → `DIN`=0. Write `0xBEEF` to `0x5000` → no register changes and `ram_we`=0.
- **Timer (`CLK_DIV`=4):** load 3 → expired rises 12 clocks after the write edge and TSTAT reads 1. Reload 0 → expired clears and stays 0.
- **Timer collision:** TCOUNT write coincides with a prescaler wrap → count = written value, no decrement, prescaler = 0.
- **Reset mid-read:** assert `Resetn`=0 between E0 and E2 → `DIN`, `LEDR`, `hex_val`, `timer_expired` all 0 immediately, timer IDLE.
